// File: rtl/morse_tx_param.sv
// Morse code keyer: latches one character (A-Z, 0-9) and keys it out as marks and spaces
// timed in whole units of UNIT_CYCLES clocks, followed by GAP_UNITS units of silence.
module morse_tx_param #(
  parameter int unsigned UNIT_CYCLES = 25000000,
  parameter int unsigned GAP_UNITS   = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       repeat_i,
  input  logic [5:0] char_code,
  output logic       morse_out,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] sym_idx
);

  localparam int unsigned MaxUnits = (GAP_UNITS > 3) ? GAP_UNITS : 3;
  localparam int unsigned CycW     = $clog2(UNIT_CYCLES);
  localparam int unsigned UnitW    = $clog2(MaxUnits);

  typedef enum logic [1:0] {StIdle, StMark, StSpace, StGap} state_e;

  // {length, pattern}; pattern is left-aligned, dash = 1, first symbol in bit 4. len 0 = invalid.
  function automatic logic [7:0] morse_lut(input logic [5:0] c);
    case (c)
      6'd0:    morse_lut = {3'd2, 5'b01000};
      6'd1:    morse_lut = {3'd4, 5'b10000};
      6'd2:    morse_lut = {3'd4, 5'b10100};
      6'd3:    morse_lut = {3'd3, 5'b10000};
      6'd4:    morse_lut = {3'd1, 5'b00000};
      6'd5:    morse_lut = {3'd4, 5'b00100};
      6'd6:    morse_lut = {3'd3, 5'b11000};
      6'd7:    morse_lut = {3'd4, 5'b00000};
      6'd8:    morse_lut = {3'd2, 5'b00000};
      6'd9:    morse_lut = {3'd4, 5'b01110};
      6'd10:   morse_lut = {3'd3, 5'b10100};
      6'd11:   morse_lut = {3'd4, 5'b01000};
      6'd12:   morse_lut = {3'd2, 5'b11000};
      6'd13:   morse_lut = {3'd2, 5'b10000};
      6'd14:   morse_lut = {3'd3, 5'b11100};
      6'd15:   morse_lut = {3'd4, 5'b01100};
      6'd16:   morse_lut = {3'd4, 5'b11010};
      6'd17:   morse_lut = {3'd3, 5'b01000};
      6'd18:   morse_lut = {3'd3, 5'b00000};
      6'd19:   morse_lut = {3'd1, 5'b10000};
      6'd20:   morse_lut = {3'd3, 5'b00100};
      6'd21:   morse_lut = {3'd4, 5'b00010};
      6'd22:   morse_lut = {3'd3, 5'b01100};
      6'd23:   morse_lut = {3'd4, 5'b10010};
      6'd24:   morse_lut = {3'd4, 5'b10110};
      6'd25:   morse_lut = {3'd4, 5'b11000};
      6'd26:   morse_lut = {3'd5, 5'b11111};
      6'd27:   morse_lut = {3'd5, 5'b01111};
      6'd28:   morse_lut = {3'd5, 5'b00111};
      6'd29:   morse_lut = {3'd5, 5'b00011};
      6'd30:   morse_lut = {3'd5, 5'b00001};
      6'd31:   morse_lut = {3'd5, 5'b00000};
      6'd32:   morse_lut = {3'd5, 5'b10000};
      6'd33:   morse_lut = {3'd5, 5'b11000};
      6'd34:   morse_lut = {3'd5, 5'b11100};
      6'd35:   morse_lut = {3'd5, 5'b11110};
      default: morse_lut = 8'h00;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CycW-1:0]  cyc_q, cyc_d;
  logic [UnitW-1:0] units_q, units_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0]       pat_q, pat_d;
  logic [2:0]       len_q, len_d;
  logic             done_q, done_d, err_q, err_d, morse_q, busy_q;

  logic [7:0] lut_v;
  logic       unit_end, state_end;

  assign lut_v     = morse_lut(char_code);
  assign unit_end  = (cyc_q == CycW'(UNIT_CYCLES - 1));
  // units_q counts remaining whole units minus one
  assign state_end = unit_end && (units_q == '0);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    units_d = units_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == StIdle) begin
      if (!abort && start) begin
        if (lut_v[7:5] != 3'd0) begin
          pat_d   = lut_v[4:0];
          len_d   = lut_v[7:5];
          idx_d   = 3'd0;
          state_d = StMark;
          cyc_d   = '0;
          units_d = lut_v[4] ? UnitW'(2) : '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (abort) begin
      state_d = StIdle;
      idx_d   = 3'd0;
      cyc_d   = '0;
      units_d = '0;
    end else if (!state_end) begin
      cyc_d = unit_end ? '0 : cyc_q + CycW'(1);
      if (unit_end) units_d = units_q - UnitW'(1);
    end else begin
      cyc_d = '0;
      case (state_q)
        StMark: begin
          if (idx_q == len_q - 3'd1) begin
            state_d = StGap;
            units_d = UnitW'(GAP_UNITS - 1);
          end else begin
            state_d = StSpace;
            units_d = '0;
          end
        end
        StSpace: begin
          state_d = StMark;
          idx_d   = idx_q + 3'd1;
          units_d = pat_q[3'd3 - idx_q] ? UnitW'(2) : '0;
        end
        default: begin
          if (repeat_i) begin
            state_d = StMark;
            idx_d   = 3'd0;
            units_d = pat_q[4] ? UnitW'(2) : '0;
          end else begin
            state_d = StIdle;
            idx_d   = 3'd0;
            units_d = '0;
            done_d  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      units_q <= '0;
      idx_q   <= 3'd0;
      pat_q   <= 5'd0;
      len_q   <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      morse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      units_q <= units_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      morse_q <= (state_d == StMark);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign morse_out = morse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sym_idx   = idx_q;

endmodule

// File: tb/tb_morse_tx_param.sv
// Bench for morse_tx_param: directed table of timing vectors, hand-written corner sequences,
// and random characters compared cycle by cycle against a dot/dash string model.
module tb_morse_tx_param;

  localparam int U = 4;
  localparam int G = 3;

  logic       clk = 1'b0;
  logic       reset, start, abort, rpt;
  logic [5:0] code;
  logic       morse_out, busy, done, err;
  logic [2:0] sym_idx;

  morse_tx_param #(.UNIT_CYCLES(U), .GAP_UNITS(G)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .repeat_i  (rpt),
    .char_code (code),
    .morse_out (morse_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sym_idx   (sym_idx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  string mtab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };

  typedef struct packed {
    logic       m;
    logic       b;
    logic [2:0] i;
    logic       d;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [5:0] vcode;
    int         done_cyc;
    int         probe_cyc;
    logic       probe_val;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle trace from cycle 1 through the done cycle
  task automatic build(input string s);
    exp_t e;
    int   d;
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      d = (s[i] == "-") ? 3 * U : U;
      e = '{m: 1'b1, b: 1'b1, i: i[2:0], d: 1'b0};
      for (int k = 0; k < d; k++) exp_q.push_back(e);
      if (i != s.len() - 1) begin
        e.m = 1'b0;
        for (int k = 0; k < U; k++) exp_q.push_back(e);
      end
    end
    d = s.len() - 1;
    e = '{m: 1'b0, b: 1'b1, i: d[2:0], d: 1'b0};
    for (int k = 0; k < G * U; k++) exp_q.push_back(e);
    e = '{m: 1'b0, b: 1'b0, i: 3'd0, d: 1'b1};
    exp_q.push_back(e);
  endtask

  task automatic rand_txn();
    logic [5:0] c;
    exp_t       e;
    if ($urandom_range(0, 3) == 0) c = 6'($urandom_range(36, 63));
    else c = 6'($urandom_range(0, 35));
    start = 1'b1;
    code  = c;
    tick();
    start = 1'b0;
    if (c > 6'd35) begin
      chk("rand_err", {15'd0, err}, 16'd1);
      chk("rand_err_busy", {15'd0, busy}, 16'd0);
      tick();
      chk("rand_err_pulse", {15'd0, err}, 16'd0);
      return;
    end
    build(mtab[c]);
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      chk("rand_wave", {9'd0, morse_out, busy, sym_idx, done, err},
          {9'd0, e.m, e.b, e.i, e.d, 1'b0});
      code  = 6'($urandom);
      start = (k < exp_q.size() - 1) ? 1'($urandom) : 1'b0;
      if (k < exp_q.size() - 1) tick();
    end
  endtask

  vec_t vecs [6];

  initial begin
    int   cyc, got_done;
    logic pv, busy_at_done;

    vecs[0] = '{vcode: 6'd4,  done_cyc: 17, probe_cyc: 4,  probe_val: 1'b1};
    vecs[1] = '{vcode: 6'd4,  done_cyc: 17, probe_cyc: 5,  probe_val: 1'b0};
    vecs[2] = '{vcode: 6'd0,  done_cyc: 33, probe_cyc: 8,  probe_val: 1'b0};
    vecs[3] = '{vcode: 6'd0,  done_cyc: 33, probe_cyc: 20, probe_val: 1'b1};
    vecs[4] = '{vcode: 6'd26, done_cyc: 89, probe_cyc: 76, probe_val: 1'b1};
    vecs[5] = '{vcode: 6'd26, done_cyc: 89, probe_cyc: 77, probe_val: 1'b0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; rpt = 1'b0; code = 6'd0;
    tick();
    tick();
    chk("reset_outs", {11'd0, morse_out, busy, done, err, 1'b0}, 16'd0);
    chk("reset_idx", {13'd0, sym_idx}, 16'd0);
    reset = 1'b0;
    tick();

    // Directed timing table
    for (int v = 0; v < 6; v++) begin
      start = 1'b1;
      code  = vecs[v].vcode;
      tick();
      cyc = 1;
      start = 1'b0;
      code = 6'd63;
      got_done = -1;
      pv = 1'bx;
      busy_at_done = 1'bx;
      while (cyc <= 200 && got_done < 0) begin
        if (cyc == vecs[v].probe_cyc) pv = morse_out;
        if (cyc == 9 && vecs[v].vcode == 6'd0) chk("A_idx9", {13'd0, sym_idx}, 16'd1);
        if (done) begin
          got_done = cyc;
          busy_at_done = busy;
        end else begin
          tick();
          cyc++;
        end
      end
      chk("tbl_done_cyc", got_done[15:0], vecs[v].done_cyc[15:0]);
      chk("tbl_probe", {15'd0, pv}, {15'd0, vecs[v].probe_val});
      chk("tbl_busy_at_done", {15'd0, busy_at_done}, 16'd0);
    end

    // Abort during 'T' at cycle 6, then restart at cycle 8
    start = 1'b1; code = 6'd19;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_morse", {15'd0, morse_out}, 16'd0);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_idx", {13'd0, sym_idx}, 16'd0);
    tick();
    chk("abort_no_done", {15'd0, done}, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_morse", {15'd0, morse_out}, 16'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Abort wins over start in IDLE
    abort = 1'b1; start = 1'b1; code = 6'd4;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_over_start", {14'd0, busy, morse_out}, 16'd0);
    tick();

    // 'E' with repeat held
    rpt = 1'b1; start = 1'b1; code = 6'd4;
    tick();
    start = 1'b0;
    for (int c = 1; c < 17; c++) tick();
    chk("rep_no_done", {15'd0, done}, 16'd0);
    for (int c = 17; c <= 20; c++) begin
      chk("rep_mark", {14'd0, busy, morse_out}, 16'd3);
      tick();
    end
    chk("rep_gap", {15'd0, morse_out}, 16'd0);
    rpt = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;

    // Invalid code 40
    start = 1'b1; code = 6'd40;
    tick();
    start = 1'b0;
    chk("inv_err", {14'd0, err, busy}, 16'd2);
    tick();
    chk("inv_err_clr", {15'd0, err}, 16'd0);

    // Reset at cycle 3 during 'M'
    start = 1'b1; code = 6'd12;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset", {10'd0, morse_out, busy, done, err, 2'd0}, 16'd0);
    chk("mid_reset_idx", {13'd0, sym_idx}, 16'd0);
    for (int c = 0; c < 40; c++) begin
      if (done || busy) chk("mid_reset_quiet", {14'd0, done, busy}, 16'd0);
      tick();
    end
    chk("mid_reset_end", {14'd0, done, busy}, 16'd0);

    // Random characters against the model
    for (int t = 0; t < 40; t++) rand_txn();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
